// File: rtl/adder_pkg.sv
// Shared types and constants for the adder result accumulator slice.
package adder_pkg;

  localparam int ADDER_RES_W = 3;
  localparam int DEF_ACC_W   = 8;
  localparam int DEF_CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/sat_add.sv
// Combinational saturating adder: W-bit accumulator plus a zero-extended adder result.
module sat_add
  import adder_pkg::*;
#(
  parameter int W = DEF_ACC_W
) (
  input  logic [W-1:0]           a,
  input  logic [ADDER_RES_W-1:0] b,
  output logic [W-1:0]           sum,
  output logic                   sat
);

  logic [W:0] full;

  // One extra bit catches the carry out; a set carry means the true sum exceeds W bits.
  always_comb begin
    full = {1'b0, a} + {{(W + 1 - ADDER_RES_W){1'b0}}, b};
    sat  = full[W];
    sum  = full[W] ? {W{1'b1}} : full[W-1:0];
  end

endmodule

// File: rtl/adder_sum_accumulator.sv
// Accumulates a programmed number of adder results into a saturating total and hands it off.
//
// Handshakes: a beat transfers on a rising edge where valid and ready are both high; ready and
// valid outputs here are decoded from registered state only, so neither depends on a same-cycle input.
module adder_sum_accumulator
  import adder_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [CNT_W-1:0]       num_samples,
  input  logic                   in_valid,
  input  logic [ADDER_RES_W-1:0] in_sum,
  output logic                   in_ready,
  output logic [ACC_W-1:0]       acc_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   overflow,
  output logic                   busy,
  output state_e                 state_dbg
);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] add_sum;
  logic             add_sat;

  sat_add #(.W(ACC_W)) u_sat_add (
    .a   (acc_q),
    .b   (in_sum),
    .sum (add_sum),
    .sat (add_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    if (abort) begin
      // Abort beats start, transfer and out_ready alike and discards the run.
      state_d = IDLE;
      acc_d   = '0;
      rem_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            acc_d   = '0;
            ovf_d   = 1'b0;
            rem_d   = num_samples;
            state_d = (num_samples != '0) ? ACCUM : DONE;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc_d = add_sum;
            ovf_d = ovf_q | add_sat;
            rem_d = rem_q - {{(CNT_W - 1){1'b0}}, 1'b1};
            if (rem_q == {{(CNT_W - 1){1'b0}}, 1'b1}) state_d = DONE;
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    acc_out   = acc_q;
    overflow  = ovf_q;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Directed bench for adder_sum_accumulator: one task per scenario, inline checks, one summary line.
module tb_adder_sum_accumulator;
  import adder_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, abort = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0] num_samples = '0;
  logic [2:0] in_sum = '0;
  logic       in_ready, out_valid, overflow, busy;
  logic [7:0] acc_out;
  state_e     state_dbg;

  logic       s_start = 1'b0, s_abort = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b0;
  logic [3:0] s_num_samples = '0;
  logic [2:0] s_in_sum = '0;
  logic       s_in_ready, s_out_valid, s_overflow, s_busy;
  logic [3:0] s_acc_out;
  state_e     s_state_dbg;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  adder_sum_accumulator #(.ACC_W(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_samples(num_samples),
    .in_valid(in_valid), .in_sum(in_sum), .in_ready(in_ready), .acc_out(acc_out),
    .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow), .busy(busy),
    .state_dbg(state_dbg)
  );

  adder_sum_accumulator #(.ACC_W(4), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .start(s_start), .abort(s_abort), .num_samples(s_num_samples),
    .in_valid(s_in_valid), .in_sum(s_in_sum), .in_ready(s_in_ready), .acc_out(s_acc_out),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .overflow(s_overflow), .busy(s_busy),
    .state_dbg(s_state_dbg)
  );

  // Advance one clock; inputs driven and outputs sampled 1ns after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [3:0] n);
    start = 1'b1;
    num_samples = n;
    cyc();
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [2:0] vals [4] = '{3'd6, 3'd6, 3'd6, 3'd3};
    tests_run++;
    if ({in_ready, out_valid, overflow, busy, acc_out} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_init: got rdy=%b ov=%b of=%b busy=%b acc=%0d, want all 0",
               in_ready, out_valid, overflow, busy, acc_out);
    end
    rst = 1'b0;
    cyc();
    start_run(4'd5);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_sum = vals[i];
      cyc();
    end
    in_valid = 1'b0;
    tests_run++;
    if (acc_out !== 8'h15 || state_dbg !== ACCUM) begin
      tests_failed++;
      $display("FAIL reset_pre: got acc=%0h state=%0d, want acc=15 state=ACCUM", acc_out, state_dbg);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({in_ready, out_valid, overflow, busy, acc_out} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_async: got rdy=%b ov=%b of=%b busy=%b acc=%0d, want all 0",
               in_ready, out_valid, overflow, busy, acc_out);
    end
    @(negedge clk);
    rst = 1'b0;
    cyc();
    tests_run++;
    if (state_dbg !== IDLE || acc_out !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_release: got state=%0d acc=%0d, want IDLE 0", state_dbg, acc_out);
    end
  endtask

  task automatic test_basic();
    logic [2:0] vals [4] = '{3'd3, 3'd6, 3'd1, 3'd5};
    logic [7:0] exp  [4] = '{8'd3, 8'd9, 8'd10, 8'd15};
    start_run(4'd4);
    tests_run++;
    if (state_dbg !== ACCUM || in_ready !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_start: got state=%0d rdy=%b busy=%b, want ACCUM 1 1", state_dbg, in_ready, busy);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_sum = vals[i];
      cyc();
      tests_run++;
      if (acc_out !== exp[i]) begin
        tests_failed++;
        $display("FAIL basic_acc[%0d]: got %0d want %0d", i, acc_out, exp[i]);
      end
    end
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || acc_out !== 8'd15) begin
      tests_failed++;
      $display("FAIL basic_done: got ov=%b rdy=%b acc=%0d, want 1 0 15", out_valid, in_ready, acc_out);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    tests_run++;
    if (state_dbg !== IDLE || out_valid !== 1'b0 || acc_out !== 8'd15 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_idle: got state=%0d ov=%b acc=%0d busy=%b, want IDLE 0 15 0",
               state_dbg, out_valid, acc_out, busy);
    end
  endtask

  task automatic test_backpressure();
    logic       vpat [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] exp  [5] = '{8'd2, 8'd2, 8'd4, 8'd4, 8'd6};
    start_run(4'd3);
    in_sum = 3'd2;
    for (int i = 0; i < 5; i++) begin
      in_valid = vpat[i];
      cyc();
      tests_run++;
      if (acc_out !== exp[i]) begin
        tests_failed++;
        $display("FAIL gap_acc[%0d]: got %0d want %0d", i, acc_out, exp[i]);
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (out_valid !== 1'b1 || acc_out !== 8'd6 || state_dbg !== DONE) begin
        tests_failed++;
        $display("FAIL gap_hold[%0d]: got ov=%b acc=%0d state=%0d, want 1 6 DONE", i, out_valid, acc_out, state_dbg);
      end
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    tests_run++;
    if (state_dbg !== IDLE || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL gap_release: got state=%0d ov=%b, want IDLE 0", state_dbg, out_valid);
    end
  endtask

  task automatic test_saturation();
    logic [3:0] s_exp  [3] = '{4'd6, 4'd12, 4'd15};
    logic       of_exp [3] = '{1'b0, 1'b0, 1'b1};
    start_run(4'd15);
    in_valid = 1'b1;
    in_sum = 3'd6;
    for (int i = 0; i < 15; i++) cyc();
    in_valid = 1'b0;
    tests_run++;
    if (acc_out !== 8'd90 || overflow !== 1'b0 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_wide: got acc=%0d of=%b ov=%b, want 90 0 1", acc_out, overflow, out_valid);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;

    s_start = 1'b1;
    s_num_samples = 4'd3;
    cyc();
    s_start = 1'b0;
    s_in_valid = 1'b1;
    s_in_sum = 3'd6;
    for (int i = 0; i < 3; i++) begin
      cyc();
      tests_run++;
      if (s_acc_out !== s_exp[i] || s_overflow !== of_exp[i]) begin
        tests_failed++;
        $display("FAIL sat_narrow[%0d]: got acc=%0d of=%b, want %0d %b", i, s_acc_out, s_overflow, s_exp[i], of_exp[i]);
      end
    end
    s_in_valid = 1'b0;
    s_out_ready = 1'b1;
    cyc();
    s_out_ready = 1'b0;
    cyc();
    tests_run++;
    if (s_state_dbg !== IDLE || s_overflow !== 1'b1 || s_acc_out !== 4'd15) begin
      tests_failed++;
      $display("FAIL sat_sticky: got state=%0d of=%b acc=%0d, want IDLE 1 15", s_state_dbg, s_overflow, s_acc_out);
    end
    s_start = 1'b1;
    s_num_samples = 4'd1;
    cyc();
    s_start = 1'b0;
    tests_run++;
    if (s_overflow !== 1'b0 || s_acc_out !== 4'd0 || s_state_dbg !== ACCUM) begin
      tests_failed++;
      $display("FAIL sat_clear: got of=%b acc=%0d state=%0d, want 0 0 ACCUM", s_overflow, s_acc_out, s_state_dbg);
    end
    s_abort = 1'b1;
    cyc();
    s_abort = 1'b0;
  endtask

  task automatic test_zero_count();
    start_run(4'd0);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (state_dbg !== DONE || out_valid !== 1'b1 || acc_out !== 8'd0 || in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL zero_done[%0d]: got state=%0d ov=%b acc=%0d rdy=%b, want DONE 1 0 0",
                 i, state_dbg, out_valid, acc_out, in_ready);
      end
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    tests_run++;
    if (state_dbg !== IDLE) begin
      tests_failed++;
      $display("FAIL zero_idle: got state=%0d want IDLE", state_dbg);
    end
  endtask

  task automatic test_abort();
    start_run(4'd4);
    in_valid = 1'b1;
    in_sum = 3'd1;
    cyc();
    cyc();
    tests_run++;
    if (acc_out !== 8'd2) begin
      tests_failed++;
      $display("FAIL abort_pre: got acc=%0d want 2", acc_out);
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    in_valid = 1'b0;
    tests_run++;
    if (state_dbg !== IDLE || acc_out !== 8'd0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_accum: got state=%0d acc=%0d busy=%b, want IDLE 0 0", state_dbg, acc_out, busy);
    end
    abort = 1'b1;
    start = 1'b1;
    num_samples = 4'd3;
    cyc();
    abort = 1'b0;
    start = 1'b0;
    tests_run++;
    if (state_dbg !== IDLE || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_start: got state=%0d busy=%b, want IDLE 0", state_dbg, busy);
    end
  endtask

  task automatic test_start_ignored();
    start_run(4'd3);
    in_valid = 1'b1;
    in_sum = 3'd7;
    cyc();
    in_valid = 1'b0;
    start = 1'b1;
    num_samples = 4'd9;
    cyc();
    start = 1'b0;
    in_valid = 1'b1;
    cyc();
    tests_run++;
    if (state_dbg !== ACCUM || acc_out !== 8'd14) begin
      tests_failed++;
      $display("FAIL ignore_mid: got state=%0d acc=%0d, want ACCUM 14", state_dbg, acc_out);
    end
    cyc();
    in_valid = 1'b0;
    tests_run++;
    if (state_dbg !== DONE || acc_out !== 8'd21) begin
      tests_failed++;
      $display("FAIL ignore_done: got state=%0d acc=%0d, want DONE 21", state_dbg, acc_out);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  initial begin
    #12;
    test_reset();
    test_basic();
    test_backpressure();
    test_saturation();
    test_zero_count();
    test_abort();
    test_start_ignored();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
